uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  Serial UART transmitter that sits directly downstream of baud_gen.
//  Accepts a parallel byte over a valid/ready handshake and serialises it LSB-first onto tx.
//  Frame: start bit, DATA_BITS data bits, optional parity bit, STOP_BITS stop bits.
//  Bit timing comes from the baud_gen clk_tick output (a toggling level). One bit period equals one full period of that signal.
// PARAMETERS
//  DATA_BITS   8  data bits per frame, legal 5..9
//  PARITY_EN   0  1 = insert parity bit after the data bits
//  PARITY_ODD  0  1 = odd parity, 0 = even parity (used only when PARITY_EN=1)
//  STOP_BITS   1  stop bits per frame, legal 1 or 2
// PORTS
//  clk        in   1          system clock; all logic is on its rising edge
//  rst        in   1          synchronous, active-high reset
//  baud_tick  in   1          toggling baud level from baud_gen clk_tick
//  tx_data    in   DATA_BITS  byte to send; sampled only at handshake
//  tx_valid   in   1          upstream has data
//  tx_ready   out  1          block can accept; high only in IDLE
//  tx         out  1          serial line; idles high; registered output
//  tx_busy    out  1          high from accept until frame end
//  tx_done    out  1          1-cycle pulse when the last stop bit completes
// BEHAVIOUR
//  Reset (sync, rst=1 at a clk edge):
//   - state=IDLE, tx=1, tx_busy=0, tx_done=0, tx_ready=1, edge register=0.
//   - Reset mid-frame aborts the frame. tx returns to 1 on the next edge, and no tx_done is issued.
//  Bit strobe:
//   - baud_q <= baud_tick; strobe = baud_tick & ~baud_q.
//   - Every state advance below occurs only in a strobe cycle.
//   - If baud_tick stops toggling, the FSM holds its state and tx holds its level.
//  Handshake:
//   - Transfer happens when tx_valid & tx_ready at a clk edge.
//   - On transfer, tx_data is latched into the shift register and state goes to SYNC; tx_busy=1 on the next cycle.
//   - tx_valid while busy is ignored, and tx_data changes while busy have no effect.
//  FSM (IDLE, SYNC, START, DATA, PARITY, STOP):
//   - IDLE: tx=1. Go to SYNC on transfer.
//   - SYNC: on strobe, tx<=0 and go to START.
//   - START: on strobe, tx<=shift[0], bit_cnt<=0, go to DATA.
//   - DATA: on strobe, shift right by 1 and increment bit_cnt.
//     - After DATA_BITS bits have been held, go to PARITY (tx<=par) if PARITY_EN=1.
//     - Otherwise go to STOP (tx<=1).
//   - PARITY: on strobe, tx<=1 and go to STOP.
//   - STOP: on strobe, decrement stop_cnt.
//     - When the last stop bit ends, go to IDLE with tx_done=1 for exactly that one cycle, and tx_busy<=0.
//  Parity:
//   - par = ^data_latched ^ PARITY_ODD, computed from the latched byte, not from live tx_data.
//  Latency and spacing:
//   - tx falls 1 clk after the first strobe following a transfer.
//   - Each bit lasts exactly one strobe interval.
//   - tx_ready rises 1 clk after tx_done, so back-to-back frames are separated by at least one idle-high bit period (the SYNC wait).
//  Widths:
//   - bit_cnt is $clog2(DATA_BITS+1) bits wide; no counter may wrap within a frame.
//   - stop_cnt is 1 bit wide.
//  Simultaneous events:
//   - tx_valid asserted in the same cycle tx_done pulses is not accepted (tx_ready=0 in that cycle).
//   - rst overrides all other inputs.
// TESTING
//  Use baud_gen with CLK_FREQ=100M and BAUD=10M, giving a bit period of 20 clk.
//  T1: 8N1, send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1.
//      Each level held 20 clk; one tx_done pulse; tx_busy high for the frame.
//  T2: PARITY_EN=1, even; send 0x07 -> parity bit 1. With PARITY_ODD=1 -> parity bit 0.
//      Frame is 11 bit periods.
//  T3: STOP_BITS=2, send 0x00 -> 1 start bit, 8 zero bits, then tx high for 2 bit periods before tx_done.
//  T4: hold tx_valid high with 0x55 then 0xAA -> two correct frames, at least 1 idle bit between them.
//      Exactly 2 handshakes; tx_data changes mid-frame are ignored.
//  T5: assert rst during data bit 3 -> tx=1 on the next clk, state IDLE, tx_ready=1, no tx_done.
//      A following 0x3C frame is correct.
//  T6: freeze baud_tick mid-frame for 100 clk -> tx holds its level; the frame resumes correctly after baud_tick toggles again.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: LSB-first UART serialiser paced by rising edges of baud_tick; byte in via tx_data/tx_valid/tx_ready, serial out on tx, status tx_busy/tx_done
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);
  typedef enum logic [2:0] {IDLE, SYNC, START, DATA, PARITY, STOP} state_e;
  state_e state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic stop_cnt_q, stop_cnt_d, par_q, par_d, tx_q, tx_d, done_q, done_d, baud_q, strobe, accept;
  assign strobe = baud_tick & ~baud_q;
  assign tx_ready = (state_q == IDLE) && !done_q;
  assign accept = tx_valid & tx_ready;
  assign tx = tx_q;
  assign tx_busy = state_q != IDLE;
  assign tx_done = done_q;
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_cnt_d = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d = par_q;
    tx_d = tx_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d = SYNC;
          shift_d = tx_data;
          par_d = (^tx_data) ^ 1'(PARITY_ODD);
          stop_cnt_d = 1'(STOP_BITS - 1);
        end
      end
      SYNC: if (strobe) begin
        tx_d = 1'b0;
        state_d = START;
      end
      START: if (strobe) begin
        tx_d = shift_q[0];
        bit_cnt_d = '0;
        state_d = DATA;
      end
      DATA: if (strobe) begin
        shift_d = shift_q >> 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LAST) begin
          state_d = PARITY_EN != 0 ? PARITY : STOP;
          tx_d = PARITY_EN != 0 ? par_q : 1'b1;
        end else tx_d = shift_q[1];
      end
      PARITY: if (strobe) begin
        tx_d = 1'b1;
        state_d = STOP;
      end
      STOP: if (strobe) begin
        if (stop_cnt_q) stop_cnt_d = 1'b0;
        else begin
          state_d = IDLE;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_cnt_q <= '0;
      stop_cnt_q <= 1'b0;
      par_q <= 1'b0;
      tx_q <= 1'b1;
      done_q <= 1'b0;
      baud_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q <= par_d;
      tx_q <= tx_d;
      done_q <= done_d;
      baud_q <= baud_tick;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx framing, parity, stop bits, handshake, reset abort and baud freeze
module tb_uart_tx;
  logic clk = 0, rst = 1, baud = 0, freeze = 0;
  int bcnt = 0, checks = 0, failures = 0, hs0 = 0, dc0 = 0;
  logic [3:0] v = '0;
  logic [7:0] d [4];
  wire [3:0] rdy, txl, busy, dn;
  always #5 clk = ~clk;
  always @(posedge clk) if (!freeze) begin
    if (bcnt == 9) begin
      bcnt <= 0;
      baud <= ~baud;
    end else bcnt <= bcnt + 1;
  end
  always @(posedge clk) begin
    if (!rst && v[0] && rdy[0]) hs0 <= hs0 + 1;
    if (dn[0]) dc0 <= dc0 + 1;
  end
  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (.clk(clk), .rst(rst), .baud_tick(baud),
    .tx_data(d[0]), .tx_valid(v[0]), .tx_ready(rdy[0]), .tx(txl[0]), .tx_busy(busy[0]), .tx_done(dn[0]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (.clk(clk), .rst(rst), .baud_tick(baud),
    .tx_data(d[1]), .tx_valid(v[1]), .tx_ready(rdy[1]), .tx(txl[1]), .tx_busy(busy[1]), .tx_done(dn[1]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (.clk(clk), .rst(rst), .baud_tick(baud),
    .tx_data(d[2]), .tx_valid(v[2]), .tx_ready(rdy[2]), .tx(txl[2]), .tx_busy(busy[2]), .tx_done(dn[2]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (.clk(clk), .rst(rst), .baud_tick(baud),
    .tx_data(d[3]), .tx_valid(v[3]), .tx_ready(rdy[3]), .tx(txl[3]), .tx_busy(busy[3]), .tx_done(dn[3]));
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send(int idx, logic [7:0] data);
    @(negedge clk);
    d[idx] = data;
    v[idx] = 1'b1;
    @(negedge clk);
    v[idx] = 1'b0;
    chk("busy_after_accept", {31'b0, busy[idx]}, 1);
  endtask
  // bits[k] is the expected line level during bit period k of the frame (start bit first)
  task automatic frame(int idx, logic [15:0] bits, int nb, int fa);
    int n = 0;
    while (txl[idx] !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("start_fall", {31'b0, txl[idx]}, 0);
    for (int k = 1; k <= 20 * nb + 1; k++) begin
      @(negedge clk);
      if (k < 20 * nb && (k % 20 == 0 || k % 20 == 19)) chk($sformatf("bit%0d_at%0d", k / 20, k), {31'b0, txl[idx]}, {31'b0, bits[k / 20]});
      if (k < 20 * nb && k % 20 == 0) chk("busy_in_frame", {31'b0, busy[idx]}, 1);
      if (k >= 20 * nb - 1) chk($sformatf("done_at%0d", k), {31'b0, dn[idx]}, {31'b0, k == 20 * nb});
      if (k == 20 * nb) chk("idle_tx", {31'b0, txl[idx]}, 1);
      if (k == 20 * nb) chk("ready_low_on_done", {31'b0, rdy[idx]}, 0);
      if (k == 20 * nb + 1) chk("ready_after_done", {31'b0, rdy[idx]}, 1);
      if (k == 20 * nb + 1) chk("busy_after_done", {31'b0, busy[idx]}, 0);
      if (k == fa) begin
        freeze = 1'b1;
        for (int j = 0; j < 100; j++) begin
          @(negedge clk);
          if (j % 25 == 24) chk("frozen_tx", {31'b0, txl[idx]}, {31'b0, bits[k / 20]});
        end
        chk("frozen_busy", {31'b0, busy[idx]}, 1);
        freeze = 1'b0;
      end
    end
  endtask
  initial begin
    int hs_base, dc_base;
    for (int i = 0; i < 4; i++) d[i] = 8'h00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_tx%0d", i), {31'b0, txl[i]}, 1);
      chk($sformatf("rst_ready%0d", i), {31'b0, rdy[i]}, 1);
      chk($sformatf("rst_busy%0d", i), {31'b0, busy[i]}, 0);
      chk($sformatf("rst_done%0d", i), {31'b0, dn[i]}, 0);
    end
    rst = 1'b0;
    send(0, 8'hA5);
    frame(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 0);
    send(1, 8'h07);
    frame(1, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 0);
    send(2, 8'h07);
    frame(2, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 0);
    send(3, 8'h00);
    frame(3, {5'b0, 2'b11, 8'h00, 1'b0}, 11, 0);
    hs_base = hs0;
    @(negedge clk);
    d[0] = 8'h55;
    v[0] = 1'b1;
    @(negedge clk);
    chk("t4_busy1", {31'b0, busy[0]}, 1);
    d[0] = 8'hAA;
    frame(0, {6'b0, 1'b1, 8'h55, 1'b0}, 10, 0);
    @(negedge clk);
    chk("t4_busy2", {31'b0, busy[0]}, 1);
    v[0] = 1'b0;
    d[0] = 8'h0F;
    frame(0, {6'b0, 1'b1, 8'hAA, 1'b0}, 10, 0);
    chk("t4_handshakes", hs0 - hs_base, 2);
    send(0, 8'hF0);
    begin
      int n = 0;
      while (txl[0] !== 1'b0 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (90) @(negedge clk);
    chk("t5_databit3", {31'b0, txl[0]}, 0);
    dc_base = dc0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_tx", {31'b0, txl[0]}, 1);
    chk("t5_ready", {31'b0, rdy[0]}, 1);
    chk("t5_busy", {31'b0, busy[0]}, 0);
    repeat (250) @(negedge clk);
    chk("t5_no_done", dc0 - dc_base, 0);
    chk("t5_idle_tx", {31'b0, txl[0]}, 1);
    send(0, 8'h3C);
    frame(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 0);
    send(0, 8'h96);
    frame(0, {6'b0, 1'b1, 8'h96, 1'b0}, 10, 50);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
